// File: rtl/sram_match_pkg.sv
// Shared types and helpers for the SRAM slice matcher and related arbiters.
package sram_match_pkg;

    // Runtime selection policy; encoding 3 is folded onto MODE_MAX_AMOUNT at decode.
    typedef enum logic [1:0] {
        MODE_MAX_AMOUNT = 2'd0,
        MODE_MAX_SPACE  = 2'd1,
        MODE_FIRST_FIT  = 2'd2
    } match_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } match_state_t;

    // Packet length is in bytes; space is counted in 8-byte units plus one.
    localparam int unsigned REQ_SHIFT = 3;

    function automatic logic [31:0] calc_req(input logic [31:0] len);
        return (len >> REQ_SHIFT) + 32'd1;
    endfunction

    function automatic match_mode_t decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_MAX_SPACE;
            2'd2:    return MODE_FIRST_FIT;
            default: return MODE_MAX_AMOUNT;
        endcase
    endfunction

endpackage

// File: rtl/sram_match_engine_if.sv
// Request/result and slice-status bundle between a write front-end, the
// shared SRAM status mux and the matcher. slave = matcher side.
interface sram_match_engine_if #(
    parameter int NUM_SRAM = 32,
    parameter int IDX_W    = $clog2(NUM_SRAM),
    parameter int LEN_W    = 9,
    parameter int SPACE_W  = 11,
    parameter int AMOUNT_W = 9,
    parameter int TICK_W   = 8
);
    logic [TICK_W-1:0]   match_threshold;
    logic [TICK_W-1:0]   match_timeout;
    logic [1:0]          match_mode;
    logic [LEN_W-1:0]    new_length;
    logic                match_enable;
    logic                match_suc;
    logic                match_fail;
    logic [IDX_W:0]      match_best_sram;
    logic [IDX_W-1:0]    scan_sram;
    logic                accessible;
    logic [SPACE_W-1:0]  free_space;
    logic [AMOUNT_W-1:0] packet_amount;

    modport master (
        output match_threshold, match_timeout, match_mode, new_length, match_enable,
        output accessible, free_space, packet_amount,
        input  match_suc, match_fail, match_best_sram, scan_sram
    );

    modport slave (
        input  match_threshold, match_timeout, match_mode, new_length, match_enable,
        input  accessible, free_space, packet_amount,
        output match_suc, match_fail, match_best_sram, scan_sram
    );
endinterface

// File: rtl/sram_match_cmp.sv
// Combinational fit/better evaluation of one candidate slice against the
// current best under the selected policy.
module sram_match_cmp
    import sram_match_pkg::*;
#(
    parameter int SPACE_W  = 11,
    parameter int AMOUNT_W = 9
) (
    input  match_mode_t         i_mode,
    input  logic                i_find,
    input  logic [SPACE_W-1:0]  i_req,
    input  logic                i_accessible,
    input  logic [SPACE_W-1:0]  i_free_space,
    input  logic [AMOUNT_W-1:0] i_packet_amount,
    input  logic [SPACE_W-1:0]  i_best_space,
    input  logic [AMOUNT_W-1:0] i_best_amount,
    output logic                o_better
);
    logic w_fit;

    // A candidate must fit before the policy is even consulted.
    always_comb begin
        w_fit    = i_accessible && (i_free_space >= i_req);
        o_better = 1'b0;
        case (i_mode)
            MODE_MAX_SPACE: o_better = w_fit && (i_free_space > i_best_space);
            MODE_FIRST_FIT: o_better = w_fit && !i_find;
            default:        o_better = w_fit && (i_packet_amount >= i_best_amount);
        endcase
    end

endmodule

// File: rtl/sram_match_engine.sv
// Write-side SRAM matcher: scans all slices from a round-robin start,
// keeps the best fitting slice and reports success or failure with a
// one-cycle pulse.
module sram_match_engine
    import sram_match_pkg::*;
#(
    parameter int NUM_SRAM = 32,
    parameter int IDX_W    = $clog2(NUM_SRAM),
    parameter int LEN_W    = 9,
    parameter int SPACE_W  = 11,
    parameter int AMOUNT_W = 9,
    parameter int TICK_W   = 8
) (
    input logic               clk,
    input logic               rst_n,
    sram_match_engine_if.slave bus
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SRAM - 1);
    localparam logic [IDX_W:0]   NONE     = (IDX_W + 1)'(NUM_SRAM);

    match_state_t        r_state;
    match_mode_t         r_mode;
    logic                r_suc;
    logic                r_fail;
    logic                r_find;
    logic [IDX_W:0]      r_best;
    logic [IDX_W-1:0]    r_scan;
    logic [IDX_W-1:0]    r_rr;
    logic [TICK_W-1:0]   r_tick;
    logic [SPACE_W-1:0]  r_req;
    logic [SPACE_W-1:0]  r_best_space;
    logic [AMOUNT_W-1:0] r_best_amount;

    logic [SPACE_W-1:0]  w_req;
    logic                w_better;
    logic                w_suc_now;
    logic                w_fail_now;
    logic [IDX_W-1:0]    w_scan_next;
    logic [TICK_W-1:0]   w_tick_next;
    logic [IDX_W-1:0]    w_rr_next;

    assign w_req = SPACE_W'(calc_req(32'(bus.new_length)));

    sram_match_cmp #(
        .SPACE_W (SPACE_W),
        .AMOUNT_W(AMOUNT_W)
    ) u_cmp (
        .i_mode         (r_mode),
        .i_find         (r_find),
        .i_req          (r_req),
        .i_accessible   (bus.accessible),
        .i_free_space   (bus.free_space),
        .i_packet_amount(bus.packet_amount),
        .i_best_space   (r_best_space),
        .i_best_amount  (r_best_amount),
        .o_better       (w_better)
    );

    // Exit decisions use the registered find; scan/tick/rr successors wrap or saturate.
    always_comb begin
        w_suc_now   = r_find && ((r_tick >= bus.match_threshold) ||
                                 (r_tick >= bus.match_timeout) ||
                                 (r_mode == MODE_FIRST_FIT));
        w_fail_now  = !r_find && (r_tick >= bus.match_timeout);
        w_scan_next = (r_scan == LAST_IDX) ? '0 : r_scan + 1'b1;
        w_tick_next = (r_tick == '1) ? r_tick : r_tick + 1'b1;
        w_rr_next   = (r_best[IDX_W-1:0] == LAST_IDX) ? '0 : r_best[IDX_W-1:0] + 1'b1;
    end

    // Search FSM with registered pulses, best tracking and round-robin start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_mode        <= MODE_MAX_AMOUNT;
            r_suc         <= 1'b0;
            r_fail        <= 1'b0;
            r_find        <= 1'b0;
            r_best        <= NONE;
            r_scan        <= '0;
            r_rr          <= '0;
            r_tick        <= '0;
            r_req         <= '0;
            r_best_space  <= '0;
            r_best_amount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_suc  <= 1'b0;
                    r_fail <= 1'b0;
                    if (bus.match_enable) begin
                        r_state       <= SCAN;
                        r_scan        <= r_rr;
                        r_tick        <= '0;
                        r_find        <= 1'b0;
                        r_best        <= NONE;
                        r_best_space  <= '0;
                        r_best_amount <= '0;
                        r_req         <= w_req;
                        r_mode        <= decode_mode(bus.match_mode);
                    end
                end
                SCAN: begin
                    if (!bus.match_enable) begin
                        r_state <= IDLE;
                        r_best  <= NONE;
                    end else begin
                        // The deciding cycle still scores its slice, except on a fail edge.
                        if (w_better && !w_fail_now) begin
                            r_best        <= {1'b0, r_scan};
                            r_best_space  <= bus.free_space;
                            r_best_amount <= bus.packet_amount;
                            r_find        <= 1'b1;
                        end
                        r_scan <= w_scan_next;
                        r_tick <= w_tick_next;
                        if (w_suc_now) begin
                            r_state <= DONE;
                            r_suc   <= 1'b1;
                        end else if (w_fail_now) begin
                            r_state <= DONE;
                            r_fail  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_suc   <= 1'b0;
                    r_fail  <= 1'b0;
                    r_state <= IDLE;
                    if (r_suc) begin
                        r_rr <= w_rr_next;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.match_suc       = r_suc;
    assign bus.match_fail      = r_fail;
    assign bus.match_best_sram = r_best;
    assign bus.scan_sram       = r_scan;

endmodule
